// File: rtl/sprite_drawer.sv
// Sprite blitter: draws a SPRITE_W x SPRITE_H character (colour-keyed) or restores the background box at (x0,y0).
// Latency: done pulse 2+2*W*H cycles after the request is seen in IDLE; no backpressure, requests are level-held and ignored while busy.
module sprite_drawer #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        drawChar,
    input  logic        drawBG,
    input  logic [8:0]  xCoordinate,
    input  logic [7:0]  yCoordinate,
    output logic [7:0]  charRomAddr,
    input  logic [8:0]  charRomData,
    output logic [16:0] bgRomAddr,
    input  logic [8:0]  bgRomData,
    output logic [8:0]  vgaX,
    output logic [7:0]  vgaY,
    output logic [8:0]  vgaColour,
    output logic        vgaPlot,
    output logic        doneChar,
    output logic        doneBG
);

    typedef enum logic [2:0] {IDLE, LATCH, FETCH, PLOT, DONE, RELEASE} state_t;
    typedef enum logic {MODE_CHAR, MODE_BG} mode_t;

    localparam logic [7:0] COL_LAST = 8'(SPRITE_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(SPRITE_H - 1);
    localparam logic [7:0] W8       = 8'(SPRITE_W);

    state_t state, state_next;
    mode_t  mode;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [7:0] col, row;

    logic        last_col, last_pix, on_screen, served_req;
    logic [9:0]  px, py;
    logic [16:0] bg_addr;
    logic [7:0]  char_addr;

    assign last_col   = (col == COL_LAST);
    assign last_pix   = last_col && (row == ROW_LAST);
    // 10-bit sums so a box hanging off the right/bottom edge never wraps back on screen
    assign px         = {1'b0, x0} + {2'b00, col};
    assign py         = {2'b00, y0} + {2'b00, row};
    assign on_screen  = (px < 10'd320) && (py < 10'd240);
    assign bg_addr    = 17'(py) * 17'd320 + 17'(px);
    assign char_addr  = row * W8 + col;
    assign served_req = (mode == MODE_BG) ? drawBG : drawChar;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            mode  <= MODE_CHAR;
            x0    <= '0;
            y0    <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // mode is taken at the IDLE decision so a request dropped during LATCH cannot flip it
                    if (drawBG)
                        mode <= MODE_BG;
                    else if (drawChar)
                        mode <= MODE_CHAR;
                end
                LATCH: begin
                    x0  <= xCoordinate;
                    y0  <= yCoordinate;
                    col <= '0;
                    row <= '0;
                end
                PLOT: begin
                    if (last_col) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + 8'd1;
                    end else begin
                        col <= col + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        charRomAddr = '0;
        bgRomAddr   = '0;
        vgaX        = '0;
        vgaY        = '0;
        vgaColour   = '0;
        vgaPlot     = 1'b0;
        doneChar    = 1'b0;
        doneBG      = 1'b0;
        case (state)
            IDLE: begin
                if (drawBG || drawChar)
                    state_next = LATCH;
            end
            LATCH: state_next = FETCH;
            FETCH: begin
                charRomAddr = char_addr;
                bgRomAddr   = on_screen ? bg_addr : '0;
                state_next  = PLOT;
            end
            PLOT: begin
                vgaX       = px[8:0];
                vgaY       = py[7:0];
                vgaColour  = (mode == MODE_BG) ? bgRomData : charRomData;
                vgaPlot    = on_screen && ((mode == MODE_BG) || (charRomData != TRANSPARENT));
                state_next = last_pix ? DONE : FETCH;
            end
            DONE: begin
                doneBG     = (mode == MODE_BG);
                doneChar   = (mode == MODE_CHAR);
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!served_req)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/sprite_drawer.md
SPRITE_DRAWER -- requirements
Module: sprite_drawer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SPRITE_W, 16, sprite width in pixels
- SPRITE_H, 16, sprite height in pixels
- TRANSPARENT, 9'h1FF, character colour code that is never plotted
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- drawChar  in  1  level request: draw the character sprite
- drawBG  in  1  level request: restore the background under the sprite box
- xCoordinate  in  9  sprite box top-left x, 0..319
- yCoordinate  in  8  sprite box top-left y, 0..239
- charRomAddr  out  8  character ROM address, row*SPRITE_W+col
- charRomData  in  9  character ROM data, RGB333, one-cycle synchronous read
- bgRomAddr  out  17  background ROM address, py*320+px
- bgRomData  in  9  background ROM data, RGB333, one-cycle synchronous read
- vgaX  out  9  pixel x to VGA adapter
- vgaY  out  8  pixel y to VGA adapter
- vgaColour  out  9  pixel colour to VGA adapter
- vgaPlot  out  1  pixel write strobe
- doneChar  out  1  one-cycle pulse: character draw finished
- doneBG  out  1  one-cycle pulse: background restore finished

Function
REQ-003 FSM states SHALL be IDLE, LATCH, FETCH, PLOT, DONE, RELEASE.
REQ-004 IDLE: if drawBG=1 -> LATCH with mode=BG; else if drawChar=1 -> LATCH with mode=CHAR; else stay; drawBG wins when both are high.
REQ-005 LATCH SHALL capture xCoordinate, yCoordinate and mode, clear col/row counters, then go to FETCH; input changes after LATCH SHALL NOT affect the draw.
REQ-006 FETCH SHALL drive the ROM address for the current (col,row), then go to PLOT.
REQ-007 PLOT SHALL present px=x0+col, py=y0+row on vgaX/vgaY, and the ROM data on vgaColour. It SHALL then advance col; on col wrap it SHALL clear col and advance row.
REQ-008 From PLOT, the FSM SHALL return to FETCH unless (col,row)=(SPRITE_W-1,SPRITE_H-1), in which case it SHALL go to DONE.
REQ-009 Scan order SHALL be row-major: col fastest, row 0 first.
REQ-010 vgaPlot SHALL be 1 only in PLOT and only when all of the following hold:
- px<320 and py<240, with px/py computed at 10 bits, no wrap;
- mode=BG, or mode=CHAR and charRomData!=TRANSPARENT.
REQ-011 Off-screen pixels SHALL still consume their FETCH/PLOT cycles and SHALL NOT issue ROM addresses out of range; bgRomAddr SHALL be 0 when clipped.
REQ-012 DONE SHALL assert doneBG (mode=BG) or doneChar (mode=CHAR) for exactly one cycle, then go to RELEASE.
REQ-013 RELEASE SHALL wait until the served request input is 0, then go to IDLE; this prevents a held request from restarting a draw.
REQ-014 Latency SHALL be fixed: request sampled in IDLE at cycle t -> done pulse at cycle t+2+2*SPRITE_W*SPRITE_H (t+514 at default size).
REQ-015 Every draw SHALL produce exactly SPRITE_W*SPRITE_H PLOT cycles, whether or not each pixel is plotted.
REQ-016 Requests arriving outside IDLE SHALL be ignored; requests still high when IDLE is re-entered SHALL be served.

Reset
REQ-017 resetn=0 at a rising clock edge SHALL force IDLE, clear counters, x0/y0 and mode.
REQ-018 During and after reset, all of vgaPlot, doneChar and doneBG SHALL be 0, and vgaX, vgaY, vgaColour, charRomAddr and bgRomAddr SHALL be 0.
REQ-019 Reset mid-draw SHALL abort the draw with no done pulse; the next draw SHALL start from (0,0).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- drawBG held at (95,205) from cycle t -> 256 vgaPlot pulses with vgaX 95..110, vgaY 205..220 in row-major order, colours equal to the BG model at py*320+px; doneBG=1 exactly at t+514; doneChar stays 0.
- drawChar at (95,205) with ROM pixel (3,2) = 9'h1FF -> 255 vgaPlot pulses, none at (98,207); doneChar pulse only.
- drawChar at (312,232) -> pixels with px>=320 or py>=240 not plotted; 64 plots at most; done still at t+514.
- Emulate the control handshake: drawBG held until doneBG, X/Y updated one cycle later, drawChar raised two cycles after doneBG -> character drawn at the new coordinates, no second BG draw.
- drawBG and drawChar high together -> BG draw only; after RELEASE, drawChar still high starts the character draw.
- resetn pulsed low at the 100th PLOT -> vgaPlot=0 from the next cycle, no done pulse; a following drawChar completes normally in 514 cycles.
